// File: rtl/song_player.sv
// Replays recorded note records from the song RAM as active-low key levels, timed by 0.01 s ticks.
// Define SONG_PLAYER_LOOP_EN to restart from address 0 at the end of each pass instead of stopping.
module song_player #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned TIME_W = 13
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [27:0]       rd_data,
    output logic              play_do,
    output logic              play_re,
    output logic              play_mi,
    output logic [1:0]        cur_key,
    output logic [TIME_W-1:0] play_time,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StAddr  = 3'd1;
    localparam logic [2:0] StRead  = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StHold  = 3'd4;
    localparam logic [2:0] StNext  = 3'd5;
    localparam logic [2:0] StDone  = 3'd6;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [TIME_W-1:0] play_time_q, play_time_d;
    logic [1:0]        cur_key_q, cur_key_d;
    logic [2:0]        keys_n_q, keys_n_d;   // {mi, re, do}, active low
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        key_q, key_d;
    logic [TIME_W-1:0] st_q, st_d;
    logic [TIME_W-1:0] dur_q, dur_d;
    logic [TIME_W-1:0] remaining_q, remaining_d;
    logic              end_of_pass;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        play_time_d = play_time_q;
        cur_key_d   = cur_key_q;
        keys_n_d    = keys_n_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        key_d       = key_q;
        st_d        = st_q;
        dur_d       = dur_q;
        remaining_d = remaining_q;
        end_of_pass = 1'b0;

        if (busy_q && tick && (play_time_q != '1)) begin
            play_time_d = play_time_q + TIME_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    rd_addr_d   = '0;
                    play_time_d = '0;
                    busy_d      = 1'b1;
                    state_d     = StAddr;
                end
            end
            StAddr: state_d = StRead;
            StRead: begin
                key_d = rd_data[27:26];
                st_d  = TIME_W'(rd_data[25:13]);
                dur_d = TIME_W'(rd_data[12:0]);
                if (rd_data[27:26] == 2'b00) begin
                    end_of_pass = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (play_time_q >= st_q) begin
                    case (key_q)
                        2'b01:   keys_n_d = 3'b110;
                        2'b10:   keys_n_d = 3'b101;
                        2'b11:   keys_n_d = 3'b011;
                        default: keys_n_d = 3'b111;
                    endcase
                    cur_key_d   = key_q;
                    // A zero duration still sounds for one tick.
                    remaining_d = (dur_q == '0) ? TIME_W'(1) : dur_q;
                    state_d     = StHold;
                end
            end
            StHold: begin
                if (tick) begin
                    if (remaining_q == TIME_W'(1)) begin
                        keys_n_d  = 3'b111;
                        cur_key_d = 2'b00;
                        state_d   = StNext;
                    end else begin
                        remaining_d = remaining_q - TIME_W'(1);
                    end
                end
            end
            StNext: begin
                if (&rd_addr_q) begin
                    end_of_pass = 1'b1;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    state_d   = StAddr;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef SONG_PLAYER_LOOP_EN
        if (end_of_pass) begin
            rd_addr_d   = '0;
            play_time_d = '0;
            done_d      = 1'b1;
            state_d     = StAddr;
        end
`else
        if (end_of_pass) begin
            state_d = StDone;
        end
`endif

        // Abort overrides everything, including a pending done pulse.
        if (stop && (state_q != StIdle)) begin
            keys_n_d  = 3'b111;
            cur_key_d = 2'b00;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            rd_addr_q   <= '0;
            play_time_q <= '0;
            cur_key_q   <= 2'b00;
            keys_n_q    <= 3'b111;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            key_q       <= 2'b00;
            st_q        <= '0;
            dur_q       <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            play_time_q <= play_time_d;
            cur_key_q   <= cur_key_d;
            keys_n_q    <= keys_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            key_q       <= key_d;
            st_q        <= st_d;
            dur_q       <= dur_d;
            remaining_q <= remaining_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign play_time = play_time_q;
    assign cur_key   = cur_key_q;
    assign play_do   = keys_n_q[0];
    assign play_re   = keys_n_q[1];
    assign play_mi   = keys_n_q[2];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: synchronous RAM model, manual tick strobes, immediate assertions.
module tb_song_player;

    localparam int unsigned AW = 13;
    localparam int unsigned TW = 13;

    logic          clock = 1'b0;
    logic          reset, start, stop, tick;
    logic [AW-1:0] rd_addr;
    logic [27:0]   rd_data;
    logic          play_do, play_re, play_mi;
    logic [1:0]    cur_key;
    logic [TW-1:0] play_time;
    logic          busy, done;

    logic [27:0] mem [0:15];
    int n_checks = 0;
    int n_pass   = 0;
    int excl_err = 0;
    logic [1:0] prev_key = 2'b00;
    logic [1:0] press_q[$];

    song_player #(.ADDR_W(AW), .TIME_W(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .play_do   (play_do),
        .play_re   (play_re),
        .play_mi   (play_mi),
        .cur_key   (cur_key),
        .play_time (play_time),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rd_data <= mem[rd_addr[3:0]];

    // Key exclusivity / cur_key consistency and press order, sampled mid-cycle.
    always @(negedge clock) begin
        if ((32'(!play_do) + 32'(!play_re) + 32'(!play_mi)) > 1) excl_err++;
        if ((play_do !== (cur_key != 2'd1)) || (play_re !== (cur_key != 2'd2)) ||
            (play_mi !== (cur_key != 2'd3))) excl_err++;
        if (cur_key != 2'b00 && prev_key == 2'b00) press_q.push_back(cur_key);
        prev_key = cur_key;
    end

    function automatic logic [27:0] rec(input logic [1:0] k, input int st, input int dur);
        return {k, st[12:0], dur[12:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic tk();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic ten();
        repeat (9) cyc();
        tk();
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_addr"}, 32'(rd_addr), 0);
        chk({p, "_time"}, 32'(play_time), 0);
        chk({p, "_key"}, 32'(cur_key), 0);
        chk({p, "_levels"}, 32'({play_do, play_re, play_mi}), 7);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
    endtask

    initial begin
        bit saw_done;
        int idle_err;
        int done_cnt;
        int busy_low;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
        cyc();
        cyc();
        chk_reset("rst");
        reset = 1'b0;
        cyc();

`ifndef SONG_PLAYER_LOOP_EN
        // Single note: do at t=5 for 3 ticks.
        mem[0] = rec(2'b01, 5, 3);
        mem[1] = '0;
        do_start();
        chk("t1_busy", 32'(busy), 1);
        cyc();
        cyc();
        repeat (4) ten();
        chk("t1_time4", 32'(play_time), 4);
        chk("t1_do_wait", 32'(play_do), 1);
        ten();
        chk("t1_do_at_tick5", 32'(play_do), 1);
        cyc();
        chk("t1_do_press", 32'(play_do), 0);
        chk("t1_key_do", 32'(cur_key), 1);
        ten();
        ten();
        repeat (9) cyc();
        chk("t1_do_held", 32'(play_do), 0);
        tk();
        chk("t1_do_release", 32'(play_do), 1);
        chk("t1_key_none", 32'(cur_key), 0);
        chk("t1_time8", 32'(play_time), 8);
        cyc();
        chk("t1_next_addr", 32'(rd_addr), 1);
        cyc();
        cyc();
        chk("t1_no_early_done", 32'(done), 0);
        cyc();
        chk("t1_done", 32'(done), 1);
        chk("t1_busy_low", 32'(busy), 0);
        cyc();
        chk("t1_done_one", 32'(done), 0);

        // Three notes with an idle gap between ticks 4 and 10.
        mem[0] = rec(2'b01, 0, 2);
        mem[1] = rec(2'b10, 2, 2);
        mem[2] = rec(2'b11, 10, 1);
        mem[3] = '0;
        press_q.delete();
        idle_err = 0;
        saw_done = 1'b0;
        do_start();
        for (int i = 0; i < 400 && !saw_done; i++) begin
            tick = ((i % 10) == 9);
            cyc();
            tick = 1'b0;
            if (play_time >= 5 && play_time <= 9 && cur_key != 2'b00) idle_err++;
            if (done) saw_done = 1'b1;
        end
        chk("t2_done", 32'(saw_done), 1);
        chk("t2_presses", 32'(press_q.size()), 3);
        chk("t2_first_do", 32'(press_q[0]), 1);
        chk("t2_second_re", 32'(press_q[1]), 2);
        chk("t2_third_mi", 32'(press_q[2]), 3);
        chk("t2_gap_idle", 32'(idle_err), 0);
        chk("t2_end_time", 32'(play_time), 11);

        // Overlap and zero duration.
        mem[0] = rec(2'b10, 0, 5);
        mem[1] = rec(2'b11, 1, 0);
        mem[2] = '0;
        do_start();
        cyc();
        cyc();
        chk("t3_re_wait", 32'(play_re), 1);
        cyc();
        chk("t3_re_press", 32'(play_re), 0);
        chk("t3_key_re", 32'(cur_key), 2);
        repeat (4) ten();
        chk("t3_re_held", 32'(play_re), 0);
        ten();
        chk("t3_re_release", 32'(play_re), 1);
        chk("t3_time5", 32'(play_time), 5);
        repeat (3) cyc();
        chk("t3_mi_wait", 32'(play_mi), 1);
        cyc();
        chk("t3_mi_press", 32'(play_mi), 0);
        chk("t3_key_mi", 32'(cur_key), 3);
        repeat (9) cyc();
        chk("t3_mi_held", 32'(play_mi), 0);
        tk();
        chk("t3_mi_release", 32'(play_mi), 1);
        repeat (4) cyc();
        chk("t3_done", 32'(done), 1);

        // Restart, ignored start while busy, stop while mi held.
        do_start();
        chk("t4_time_clear", 32'(play_time), 0);
        chk("t4_addr_clear", 32'(rd_addr), 0);
        repeat (3) cyc();
        repeat (5) ten();
        repeat (4) cyc();
        chk("t4_key_mi", 32'(cur_key), 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t4_start_ignored_addr", 32'(rd_addr), 1);
        chk("t4_start_ignored_key", 32'(cur_key), 3);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t4_stop_levels", 32'({play_do, play_re, play_mi}), 7);
        chk("t4_stop_key", 32'(cur_key), 0);
        chk("t4_stop_busy", 32'(busy), 0);
        chk("t4_stop_no_done", 32'(done), 0);
        cyc();
        chk("t4_stop_no_done_later", 32'(done), 0);
        start = 1'b1;
        stop = 1'b1;
        cyc();
        start = 1'b0;
        stop = 1'b0;
        chk("t4_stop_wins", 32'(busy), 0);
        do_start();
        chk("t4_replay_busy", 32'(busy), 1);
        chk("t4_replay_addr", 32'(rd_addr), 0);
        chk("t4_replay_time", 32'(play_time), 0);

        // Reset during HOLD.
        repeat (3) cyc();
        ten();
        chk("t5_re_held", 32'(play_re), 0);
        chk("t5_time1", 32'(play_time), 1);
        reset = 1'b1;
        cyc();
        chk_reset("t5_rst");
        reset = 1'b0;
        cyc();
`else
        // Two-note song looping: three passes, busy never drops.
        mem[0] = rec(2'b01, 0, 1);
        mem[1] = rec(2'b10, 0, 1);
        mem[2] = '0;
        press_q.delete();
        done_cnt = 0;
        busy_low = 0;
        do_start();
        for (int i = 0; i < 600 && done_cnt < 3; i++) begin
            tick = ((i % 10) == 9);
            cyc();
            tick = 1'b0;
            if (done) done_cnt++;
            if (!busy) busy_low++;
        end
        chk("loop_done_pulses", 32'(done_cnt), 3);
        chk("loop_busy_kept", 32'(busy_low), 0);
        chk("loop_presses", 32'(press_q.size()), 6);
        chk("loop_addr_wrap", 32'(rd_addr), 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("loop_stop_busy", 32'(busy), 0);
        chk("loop_stop_levels", 32'({play_do, play_re, play_mi}), 7);
`endif

        chk("excl_consistency", 32'(excl_err), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
